// File: rtl/four_12_12_st0_mem_rd_seq_pkg.sv
// Shared types and constants for the stage-0 memory read sequencer.
// Interface structs match the stage-0 memory wrapper field order.
package four_12_12_st0_mem_rd_seq_pkg;

  localparam int ST0_NUM_IN  = 12;
  localparam int ST0_NUM_OUT = 12;
  localparam int ST0_RD_LAT  = 1;
  localparam int DATA_AW     = 9;
  localparam int TAP_AW      = 5;
  localparam int BIAS_AW     = 4;
  localparam int TAP_W       = 384;
  localparam int WORD_W      = 32;
  localparam int K_W         = 4;
  // One slot per read that can be in the memory pipe plus one held beat.
  localparam int FIFO_DEPTH  = 1 + ST0_RD_LAT;

  typedef struct packed {
    logic              wr_en;
    logic [TAP_AW-1:0] wr_addr;
    logic              rd_en;
    logic [TAP_AW-1:0] rd_addr;
  } tap_int_384_5;

  typedef struct packed {
    logic               wr_en;
    logic [BIAS_AW-1:0] wr_addr;
    logic               rd_en;
    logic [BIAS_AW-1:0] rd_addr;
  } bias_int_32_4;

  typedef struct packed {
    logic               wr_en;
    logic [DATA_AW-1:0] wr_addr;
    logic               rd_en;
    logic [DATA_AW-1:0] rd_addr;
  } data_int_32_9;

  typedef struct packed {
    logic [TAP_W-1:0]  tap;
    logic [WORD_W-1:0] bias;
    logic [WORD_W-1:0] data;
    logic [K_W-1:0]    k;
    logic              first;
    logic              last;
    logic              sample_last;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/four_12_12_st0_rd_fifo.sv
// Two-entry fall-through skid FIFO between the memory capture stage and the MAC stream.
// Handshake: a beat moves when out_valid && out_ready; payload holds while stalled.
module four_12_12_st0_rd_fifo
  import four_12_12_st0_mem_rd_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  beat_t      push_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output beat_t      out_beat,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  held;
  logic  pop;
  logic  store;

  // An empty FIFO passes the incoming beat straight through; it is only
  // stored when it cannot leave in the same cycle.
  assign held      = (count != 2'd0);
  assign out_valid = held | push;
  assign pop       = out_valid & out_ready;
  assign store     = push & ~(~held & pop);

  always_comb begin
    out_beat = '0;
    if (held)      out_beat = mem[rd_ptr];
    else if (push) out_beat = push_beat;
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_beat;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (store)        wr_ptr <= ~wr_ptr;
      if (pop && held)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, store} - {1'b0, pop & held};
    end
  end

endmodule

// File: rtl/four_12_12_st0_mem_rd_seq.sv
// Stage-0 read sequencer: walks samples x neurons x inputs over the tap/bias/data
// memories and streams each read as one beat to the MAC stage.
module four_12_12_st0_mem_rd_seq
  import four_12_12_st0_mem_rd_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         num_samples,
  input  logic [DATA_AW-1:0]  data_base,
  output tap_int_384_5        tap_int,
  output bias_int_32_4        bias_int,
  output data_int_32_9        data_int,
  input  logic [TAP_W-1:0]    tap_int_rd_data,
  input  logic [WORD_W-1:0]   bias_int_rd_data,
  input  logic [WORD_W-1:0]   data_int_rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAP_W-1:0]    out_tap,
  output logic [WORD_W-1:0]   out_bias,
  output logic [WORD_W-1:0]   out_data,
  output logic [K_W-1:0]      out_k,
  output logic                out_first,
  output logic                out_last,
  output logic                out_sample_last,
  output logic                busy,
  output logic                done
);

  localparam logic [K_W-1:0] K_LAST = K_W'(ST0_NUM_IN - 1);
  localparam logic [K_W-1:0] N_LAST = K_W'(ST0_NUM_OUT - 1);

  state_t             state;
  logic [15:0]        num_q;
  logic [15:0]        s;
  logic [K_W-1:0]     n;
  logic [K_W-1:0]     k;
  logic [DATA_AW-1:0] ptr;
  logic               outstanding;
  logic [K_W-1:0]     cap_k;
  logic [K_W-1:0]     cap_n;
  logic [1:0]         fifo_count;
  logic               issue;
  logic               last_issue;
  logic               fifo_pop;
  logic               last_accept;
  beat_t              cap_beat;
  beat_t              head;

  // Reads already in the FIFO or in the memory pipe never exceed the FIFO depth.
  assign issue      = (state == ST_ISSUE) &&
                      ((32'(fifo_count) + 32'(outstanding)) < FIFO_DEPTH);
  assign last_issue = issue && (s == num_q - 16'd1) && (n == N_LAST) && (k == K_LAST);
  assign fifo_pop   = out_valid & out_ready;
  assign last_accept = (state == ST_DRAIN) && fifo_pop &&
                       ((32'(fifo_count) + 32'(outstanding)) == 1);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    tap_int          = '0;
    bias_int         = '0;
    data_int         = '0;
    tap_int.rd_en    = issue;
    tap_int.rd_addr  = {1'b0, n};
    bias_int.rd_en   = issue;
    bias_int.rd_addr = n;
    data_int.rd_en   = issue;
    data_int.rd_addr = ptr;
  end

  always_comb begin
    cap_beat             = '0;
    cap_beat.tap         = tap_int_rd_data;
    cap_beat.bias        = bias_int_rd_data;
    cap_beat.data        = data_int_rd_data;
    cap_beat.k           = cap_k;
    cap_beat.first       = (cap_k == '0);
    cap_beat.last        = (cap_k == K_LAST);
    cap_beat.sample_last = (cap_k == K_LAST) && (cap_n == N_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      num_q       <= '0;
      s           <= '0;
      n           <= '0;
      k           <= '0;
      ptr         <= '0;
      outstanding <= 1'b0;
      cap_k       <= '0;
      cap_n       <= '0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= issue;
      if (issue) begin
        cap_k <= k;
        cap_n <= n;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_samples == 16'd0) begin
              done <= 1'b1;
            end else begin
              num_q <= num_samples;
              s     <= '0;
              n     <= '0;
              k     <= '0;
              ptr   <= data_base;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            if (k == K_LAST) begin
              k <= '0;
              if (n == N_LAST) begin
                // Next sample begins right after this sample's last input.
                n   <= '0;
                s   <= s + 16'd1;
                ptr <= ptr + 1'b1;
              end else begin
                n   <= n + 1'b1;
                ptr <= ptr - DATA_AW'(ST0_NUM_IN - 1);
              end
            end else begin
              k   <= k + 1'b1;
              ptr <= ptr + 1'b1;
            end
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_accept) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  four_12_12_st0_rd_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (outstanding),
    .push_beat (cap_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beat  (head),
    .count     (fifo_count)
  );

  assign out_tap         = head.tap;
  assign out_bias        = head.bias;
  assign out_data        = head.data;
  assign out_k           = head.k;
  assign out_first       = head.first;
  assign out_last        = head.last;
  assign out_sample_last = head.sample_last;

endmodule
